// File: rtl/triangle_loader.sv
// rtl/triangle_loader.sv - byte stream to triangle RAM writer with frame-safe commit of the triangle count
module triangle_loader #(
    parameter int N_TRIS    = 712,
    parameter int TRI_WORDS = 12,
    parameter int TRI_BITS  = TRI_WORDS * 32,
    parameter int ADDR_W    = $clog2(N_TRIS),
    parameter int CNT_W     = $clog2(N_TRIS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                feeder_busy,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [TRI_BITS-1:0] mem_wdata,
    output logic [CNT_W-1:0]    tri_count,
    output logic                count_valid,
    output logic                busy,
    output logic                err
);
    localparam int BYTES = TRI_WORDS * 4;
    localparam int BC_W  = $clog2(BYTES);
    localparam logic [BC_W-1:0]  LAST_BC = BC_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(N_TRIS);
    localparam logic [7:0] CMD_BEGIN  = 8'hA5;
    localparam logic [7:0] CMD_TRI    = 8'h5A;
    localparam logic [7:0] CMD_COMMIT = 8'hC3;

    typedef enum logic [1:0] {IDLE, PAYLOAD, WRITE, COMMIT_WAIT} state_t;

    state_t              state;
    state_t              next_state;
    logic [BC_W-1:0]     byte_cnt;
    logic [TRI_BITS-1:0] rec;
    logic [CNT_W-1:0]    wr_idx;
    logic                accept;
    logic                last_byte;
    logic                full;

    assign accept    = in_valid && in_ready;
    assign last_byte = accept && (state == PAYLOAD) && (byte_cnt == LAST_BC);
    assign full      = (wr_idx == MAX_IDX);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_data == CMD_TRI) begin
                        next_state = PAYLOAD;
                    end else if (in_data == CMD_COMMIT) begin
                        next_state = COMMIT_WAIT;
                    end
                end
            end
            PAYLOAD: begin
                if (last_byte) begin
                    next_state = WRITE;
                end
            end
            WRITE: next_state = IDLE;
            COMMIT_WAIT: begin
                if (!feeder_busy) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Write strobe, address and record are registered on the last byte so they line up with WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            tri_count   <= '0;
            count_valid <= 1'b0;
            err         <= 1'b0;
            wr_idx      <= '0;
            byte_cnt    <= '0;
            rec         <= '0;
        end else begin
            in_ready    <= (next_state == IDLE) || (next_state == PAYLOAD);
            mem_we      <= 1'b0;
            count_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        byte_cnt <= '0;
                        case (in_data)
                            CMD_BEGIN: begin
                                wr_idx <= '0;
                                err    <= 1'b0;
                            end
                            CMD_TRI, CMD_COMMIT: ;
                            default: err <= 1'b1;
                        endcase
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        rec[{byte_cnt, 3'b000} +: 8] <= in_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (last_byte && !full) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_idx[ADDR_W-1:0];
                            mem_wdata <= {in_data, rec[TRI_BITS-9:0]};
                        end
                    end
                end
                WRITE: begin
                    if (full) begin
                        err <= 1'b1;
                    end else begin
                        wr_idx <= wr_idx + 1'b1;
                    end
                end
                COMMIT_WAIT: begin
                    if (!feeder_busy) begin
                        tri_count   <= wr_idx;
                        count_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_triangle_loader.sv
// tb/tb_triangle_loader.sv - scoreboard bench for triangle_loader (full-size and two-record instances)
module tb_triangle_loader;
    localparam int NA = 712;
    localparam int NB = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         feeder_busy;

    logic         in_ready_a, mem_we_a, count_valid_a, busy_a, err_a;
    logic [9:0]   mem_addr_a;
    logic [383:0] mem_wdata_a;
    logic [9:0]   tri_count_a;

    logic         in_ready_b, mem_we_b, count_valid_b, busy_b, err_b;
    logic [0:0]   mem_addr_b;
    logic [383:0] mem_wdata_b;
    logic [1:0]   tri_count_b;

    triangle_loader dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .feeder_busy(feeder_busy), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .tri_count(tri_count_a), .count_valid(count_valid_a), .busy(busy_a), .err(err_a)
    );

    triangle_loader #(.N_TRIS(NB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .feeder_busy(feeder_busy), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .tri_count(tri_count_b), .count_valid(count_valid_b), .busy(busy_b), .err(err_b)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int idx_a = 0;
    int idx_b = 0;
    int           q_addr_a[$], q_addr_b[$], q_cnt_a[$], q_cnt_b[$];
    logic [383:0] q_data_a[$], q_data_b[$];
    logic [383:0] last_wdata_a = '0;
    int           ea, eb;
    logic [383:0] da, db;

    task automatic check(input string name, input logic ok, input logic [383:0] act, input logic [383:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [383:0] mk_rec(input logic [7:0] base);
        logic [383:0] r;
        for (int k = 0; k < 48; k++) r[k*8 +: 8] = base + 8'(k);
        return r;
    endfunction

    always @(negedge clk) begin
        if (mem_we_a) begin
            if (q_addr_a.size() == 0) begin
                check("write_a_unexpected", 1'b0, 384'(mem_addr_a), 384'(0));
            end else begin
                ea = q_addr_a.pop_front();
                da = q_data_a.pop_front();
                check("write_a_addr", 32'(mem_addr_a) == ea, 384'(mem_addr_a), 384'(ea));
                check("write_a_data", mem_wdata_a == da, mem_wdata_a, da);
                last_wdata_a = mem_wdata_a;
            end
        end
        if (mem_we_b) begin
            if (q_addr_b.size() == 0) begin
                check("write_b_unexpected", 1'b0, 384'(mem_addr_b), 384'(0));
            end else begin
                eb = q_addr_b.pop_front();
                db = q_data_b.pop_front();
                check("write_b_addr", 32'(mem_addr_b) == eb, 384'(mem_addr_b), 384'(eb));
                check("write_b_data", mem_wdata_b == db, mem_wdata_b, db);
            end
        end
        if (count_valid_a) begin
            if (q_cnt_a.size() == 0) begin
                check("count_a_unexpected", 1'b0, 384'(tri_count_a), 384'(0));
            end else begin
                ea = q_cnt_a.pop_front();
                check("count_a", 32'(tri_count_a) == ea, 384'(tri_count_a), 384'(ea));
            end
        end
        if (count_valid_b) begin
            if (q_cnt_b.size() == 0) begin
                check("count_b_unexpected", 1'b0, 384'(tri_count_b), 384'(0));
            end else begin
                eb = q_cnt_b.pop_front();
                check("count_b", 32'(tri_count_b) == eb, 384'(tri_count_b), 384'(eb));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready_a && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check("handshake_timeout", 1'b0, 384'(t), 384'(200));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_tri(input logic [7:0] base, input bit gaps);
        bit wa, wb;
        wa = (idx_a < NA);
        wb = (idx_b < NB);
        if (wa) begin q_addr_a.push_back(idx_a); q_data_a.push_back(mk_rec(base)); idx_a++; end
        if (wb) begin q_addr_b.push_back(idx_b); q_data_b.push_back(mk_rec(base)); idx_b++; end
        send_byte(8'h5A, gaps);
        for (int k = 0; k < 48; k++) send_byte(base + 8'(k), gaps);
        check("write_latency", mem_we_a == wa && mem_we_b == wb, 384'({mem_we_a, mem_we_b}), 384'({wa, wb}));
        @(posedge clk); #1;
        check("write_single", !mem_we_a && !mem_we_b, 384'({mem_we_a, mem_we_b}), 384'(0));
    endtask

    task automatic commit(input int hold);
        bit ok;
        logic [9:0] prev;
        prev = tri_count_a;
        feeder_busy = (hold > 0);
        send_byte(8'hC3, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (in_ready_a || count_valid_a || tri_count_a != prev || !busy_a) ok = 1'b0;
            @(posedge clk); #1;
        end
        if (hold > 0) check("commit_hold", ok, 384'(tri_count_a), 384'(prev));
        q_cnt_a.push_back(idx_a);
        q_cnt_b.push_back(idx_b);
        feeder_busy = 1'b0;
        @(posedge clk); #1;
        check("count_valid_edge", count_valid_a && count_valid_b, 384'({count_valid_a, count_valid_b}), 384'(3));
        @(posedge clk); #1;
        check("count_valid_single", !count_valid_a && in_ready_a, 384'({count_valid_a, in_ready_a}), 384'(1));
    endtask

    task automatic begin_cmd();
        send_byte(8'hA5, 1'b0);
        idx_a = 0;
        idx_b = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h5A;
        feeder_busy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_state",
              !in_ready_a && tri_count_a == 0 && !err_a && !mem_we_a && !busy_a && !count_valid_a &&
              mem_addr_a == 0 && mem_wdata_a == 0,
              384'({in_ready_a, err_a, mem_we_a, busy_a, count_valid_a, tri_count_a}), 384'(0));
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", in_ready_a, 384'(in_ready_a), 384'(1));

        // single triangle 00..2F
        begin_cmd();
        send_tri(8'h00, 1'b0);
        check("word0", last_wdata_a[31:0] == 32'h03020100, 384'(last_wdata_a[31:0]), 384'(32'h03020100));
        check("word11", last_wdata_a[383:352] == 32'h2F2E2D2C, 384'(last_wdata_a[383:352]), 384'(32'h2F2E2D2C));
        commit(0);

        // second record appended, commit held off by the feeder for 50 cycles
        send_tri(8'h40, 1'b0);
        commit(50);

        // gapped stream of three records; the two-record instance overflows on the third
        begin_cmd();
        send_tri(8'h10, 1'b1);
        send_tri(8'h60, 1'b1);
        send_tri(8'hC0, 1'b1);
        commit(0);
        check("overflow_err", err_b && !err_a, 384'({err_a, err_b}), 384'(1));
        begin_cmd();
        check("begin_clears_err", !err_b, 384'(err_b), 384'(0));

        // illegal command byte
        send_byte(8'h77, 1'b0);
        check("bad_cmd_err", err_a && !busy_a && in_ready_a, 384'({err_a, busy_a, in_ready_a}), 384'(5));
        begin_cmd();
        check("bad_cmd_cleared", !err_a, 384'(err_a), 384'(0));

        // reset partway through a payload, then a clean upload
        send_byte(8'h5A, 1'b0);
        for (int k = 0; k < 20; k++) send_byte(8'hEE, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_reset", tri_count_a == 0 && !in_ready_a && !busy_a, 384'({tri_count_a, in_ready_a, busy_a}), 384'(0));
        idx_a = 0;
        idx_b = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        begin_cmd();
        send_tri(8'h80, 1'b0);
        commit(0);

        repeat (3) @(posedge clk);
        #1;
        check("queues_drained",
              q_addr_a.size() == 0 && q_addr_b.size() == 0 && q_cnt_a.size() == 0 && q_cnt_b.size() == 0,
              384'(q_addr_a.size() + q_addr_b.size() + q_cnt_a.size() + q_cnt_b.size()), 384'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
